// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, flag bit positions and writeback entry type shared by the result stage
package alu_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        SHL   = 4'd5,
        SHR_L = 4'd6,
        SHR_A = 4'd7
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Default datapath width; the stage re-declares the entry at its own N
    localparam int ALU_N = 8;

    typedef struct packed {
        logic [ALU_N-1:0] result;
        logic [3:0]       flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational N/Z/C/V derivation from opcode, operands, result and adder carry
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] result,
    input  logic         add_carry,
    output logic [3:0]   flags
);

    localparam int W = $clog2(N);
    localparam logic [N-1:0] NB = N'(N);

    logic [W-1:0] shl_idx;
    logic [W-1:0] shr_idx;
    logic         in_range;
    logic         over;
    logic         c;
    logic         v;

    // Modular index arithmetic is exact whenever 1 <= b <= N, the only case it is used
    assign shl_idx  = W'(N) - W'(b);
    assign shr_idx  = W'(b) - W'(1);
    assign in_range = (b != '0) && (b <= NB);
    assign over     = b > NB;

    // Carry/overflow per opcode; logic ops and undefined codes leave both clear
    always_comb begin
        c = 1'b0;
        v = 1'b0;
        case (alu_op_t'(op))
            ADD: begin
                c = add_carry;
                v = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end
            SUB: begin
                c = add_carry;
                v = (a[N-1] == ~b[N-1]) && (result[N-1] != a[N-1]);
            end
            SHL:     c = in_range && a[shl_idx];
            SHR_L:   c = in_range && a[shr_idx];
            SHR_A:   c = in_range ? a[shr_idx] : over && a[N-1];
            default: c = 1'b0;
        endcase
    end

    assign flags[FLAG_N] = result[N-1];
    assign flags[FLAG_Z] = result == '0;
    assign flags[FLAG_C] = c;
    assign flags[FLAG_V] = v;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry registered skid buffer capturing ALU results with flags (optional ALU_RESULT_STAGE_PERF_EN pop counter)
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [3:0]   OP,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] RESULT,
    input  logic         ADD_CARRY,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [N-1:0] OUT_RESULT,
    output logic [3:0]   OUT_FLAGS
`ifdef ALU_RESULT_STAGE_PERF_EN
    ,
    output logic [31:0]  PERF_CNT
`endif
);

    typedef struct packed {
        logic [N-1:0] result;
        logic [3:0]   flags;
    } entry_t;

    entry_t     head;
    entry_t     tail;
    entry_t     cap;
    logic [3:0] cap_flags;
    logic [1:0] count;
    logic       push;
    logic       pop;

    alu_flag_gen #(.N(N)) u_flag_gen (
        .op        (OP),
        .a         (A),
        .b         (B),
        .result    (RESULT),
        .add_carry (ADD_CARRY),
        .flags     (cap_flags)
    );

    assign cap        = {RESULT, cap_flags};
    assign IN_READY   = count != 2'd2;
    assign OUT_VALID  = count != 2'd0;
    assign push       = IN_VALID && IN_READY;
    assign pop        = OUT_VALID && OUT_READY;
    assign OUT_RESULT = head.result;
    assign OUT_FLAGS  = head.flags;

    // Head is the output register; tail only fills when a push lands behind a stalled head
    always_ff @(posedge CLK) begin
        if (!RST) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            head  <= (push && (count == 2'd0 || pop)) ? cap : (pop && count == 2'd2) ? tail : head;
            tail  <= (push && count == 2'd1 && !pop) ? cap : tail;
        end
    end

`ifdef ALU_RESULT_STAGE_PERF_EN
    // Free-running pop counter, wraps naturally at 32 bits
    always_ff @(posedge CLK) begin
        PERF_CNT <= !RST ? 32'd0 : PERF_CNT + 32'(pop);
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench for alu_result_stage (ALU_RESULT_STAGE_PERF_EN adds counter checks)
module tb_alu_result_stage;

    typedef struct packed {
        logic [7:0] r;
        logic [3:0] f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [7:0] result = 8'd0;
    logic       add_carry = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic [3:0] out_flags;
`ifdef ALU_RESULT_STAGE_PERF_EN
    logic [31:0] perf_cnt;
`endif

    exp_t       q[$];
    exp_t       pending;
    int         checks = 0;
    int         errors = 0;
    bit         done;
    logic [3:0] r_op;
    logic [7:0] r_a, r_b, r_r;
    logic       r_cy;

    alu_result_stage #(.N(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .OP         (op),
        .A          (a),
        .B          (b),
        .RESULT     (result),
        .ADD_CARRY  (add_carry),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .OUT_RESULT (out_result),
        .OUT_FLAGS  (out_flags)
`ifdef ALU_RESULT_STAGE_PERF_EN
        ,
        .PERF_CNT   (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] r, input logic cy);
        int   s;
        logic c;
        logic v;
        s = int'(y);
        c = 1'b0;
        v = 1'b0;
        case (o)
            4'd0: begin c = cy; v = (x[7] == y[7]) && (r[7] != x[7]); end
            4'd1: begin c = cy; v = (x[7] != y[7]) && (r[7] != x[7]); end
            4'd5: if (s >= 1 && s <= 8) c = x[8-s];
            4'd6: if (s >= 1 && s <= 8) c = x[s-1];
            4'd7: if (s >= 1 && s <= 8) c = x[s-1]; else if (s > 8) c = x[7];
            default: c = 1'b0;
        endcase
        return {r[7], r == 8'd0, c, v};
    endfunction

    // Pop side compares the head against the oldest expectation; push side records accepted inputs
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
                else begin
                    e = q.pop_front();
                    check("out_result", 32'(out_result), 32'(e.r));
                    check("out_flags", 32'(out_flags), 32'(e.f));
                end
            end
            if (in_valid && in_ready) q.push_back(pending);
        end
    end

    task automatic drive(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] r, input logic cy, input logic [3:0] f);
        op = o; a = x; b = y; result = r; add_carry = cy;
        pending = {r, f};
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] r, input logic cy, input logic [3:0] f);
        drive(o, x, y, r, cy, f);
        wait_accept();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        out_ready = 1'b1;
        push(4'd6, 8'h0B, 8'd1, 8'h05, 1'b0, 4'b0010);
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        push(4'd7, 8'h8B, 8'd37, 8'hFF, 1'b0, 4'b1010);
        push(4'd6, 8'h8B, 8'd37, 8'h00, 1'b0, 4'b0100);
        push(4'd5, 8'h81, 8'd1, 8'h02, 1'b0, 4'b0010);
        push(4'd5, 8'h81, 8'd8, 8'h00, 1'b0, 4'b0110);
        push(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 4'b1001);
        push(4'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 4'b0011);
        push(4'd9, 8'hFF, 8'hFF, 8'h80, 1'b1, 4'b1000);
        repeat (3) @(posedge clk);
        #1;

        out_ready = 1'b0;
        push(4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 4'b0000);
        push(4'd3, 8'h0F, 8'h80, 8'h8F, 1'b0, 4'b1000);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        drive(4'd4, 8'hAA, 8'hAA, 8'h00, 1'b0, 4'b0100);
        repeat (3) begin
            @(negedge clk);
            check("stall_head", 32'(out_result), 32'h30);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        repeat (4) @(posedge clk);
        #1;

        push(4'd0, 8'h01, 8'h01, 8'h02, 1'b0, 4'b0000);
        push(4'd1, 8'h05, 8'h05, 8'h00, 1'b1, 4'b0110);
        @(negedge clk);
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_head", 32'(out_result), 32'h00);
        @(posedge clk); #1;
        @(negedge clk);
        check("pp_drained", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        push(4'd2, 8'hFF, 8'h0F, 8'h0F, 1'b0, 4'b0000);
        push(4'd3, 8'h01, 8'h02, 8'h03, 1'b0, 4'b0000);
        rst = 1'b0;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", 32'(out_result), 32'd0);
        check("mid_rst_flags", 32'(out_flags), 32'd0);
        @(posedge clk); #1;

`ifdef ALU_RESULT_STAGE_PERF_EN
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(4'd4, 8'(i), 8'h01, 8'(i + 1), 1'b0, model(4'd4, 8'(i), 8'h01, 8'(i + 1), 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("perf_five", perf_cnt, 32'd5);
        force dut.PERF_CNT = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.PERF_CNT;
        @(posedge clk); #1;
        push(4'd2, 8'h0F, 8'hF0, 8'h00, 1'b0, 4'b0100);
        repeat (3) @(posedge clk);
        #1;
        check("perf_wrap", perf_cnt, 32'd0);
`endif

        done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    r_op = 4'($urandom_range(0, 9));
                    r_a  = 8'($urandom);
                    r_b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
                    r_r  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
                    r_cy = 1'($urandom);
                    push(r_op, r_a, r_b, r_r, r_cy, model(r_op, r_a, r_b, r_r, r_cy));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
        @(negedge clk);
        check("final_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
